// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, result-unit select encodings and flag bit positions.
// Used by alu_result_stage (optional parity output guarded by ALU_RESULT_PARITY_EN).
package alu_pkg;

   // Logical and comparator opcodes; opcode[3]==0 selects the arithmetic unit
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_NOT = 4'b1011;
   localparam logic [3:0] OP_EQ  = 4'b1100;
   localparam logic [3:0] OP_NE  = 4'b1101;
   localparam logic [3:0] OP_GT  = 4'b1110;
   localparam logic [3:0] OP_LT  = 4'b1111;

   // Result source chosen by opcode[3:2]
   typedef enum logic [1:0] {
      SEL_ARITH_LO = 2'b00,
      SEL_ARITH_HI = 2'b01,
      SEL_LOGIC    = 2'b10,
      SEL_COMP     = 2'b11
   } unit_sel_e;

   // Bit positions inside the 4-bit {N,V,C,Z} flag vector
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;
   localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with fill count, full and empty.
// rdata shows the head entry; when empty it holds the last entry popped (0 after reset).
module alu_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FILL_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic [FILL_W-1:0] count,
   output logic              full,
   output logic              empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] last_q;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FILL_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         // DEPTH is a power of two, so pointer increments wrap naturally
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            last_q <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + FILL_W'(1);
            2'b01:   count <= count - FILL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only ever read while count marks it as written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: selects the unit result, builds {N,V,C,Z} and buffers it.
// Define ALU_RESULT_PARITY_EN to add the per-entry even-parity output out_parity.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [DATA_W:0]   in_arith,
   input  logic              in_ovf,
   input  logic [DATA_W-1:0] in_logic,
   input  logic [DATA_W-1:0] in_comp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [3:0]        out_flags,
   output logic [3:0]        out_opcode,
   output logic [CNT_W-1:0]  op_count
`ifdef ALU_RESULT_PARITY_EN
   ,
   output logic              out_parity
`endif
);

   localparam int FILL_W = $clog2(DEPTH + 1);
`ifdef ALU_RESULT_PARITY_EN
   localparam int PAY_W = DATA_W + 2 * FLAG_W + 1;
`else
   localparam int PAY_W = DATA_W + 2 * FLAG_W;
`endif

   logic [DATA_W-1:0] result;
   logic [FLAG_W-1:0] flags;
   logic [PAY_W-1:0]  push_data;
   logic [PAY_W-1:0]  head_data;
   logic [FILL_W-1:0] fill;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      result = in_arith[DATA_W-1:0];
      case (unit_sel_e'(in_opcode[3:2]))
         SEL_LOGIC: result = in_logic;
         SEL_COMP:  result = in_comp;
         default:   result = in_arith[DATA_W-1:0];
      endcase
   end

   // Carry and overflow are only meaningful for arithmetic opcodes
   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[DATA_W-1];
      flags[FLAG_C] = !in_opcode[3] && in_arith[DATA_W];
      flags[FLAG_V] = !in_opcode[3] && in_ovf;
   end

`ifdef ALU_RESULT_PARITY_EN
   assign push_data = {^{result, flags}, in_opcode, flags, result};
`else
   assign push_data = {in_opcode, flags, result};
`endif

   assign in_ready  = (fill < FILL_W'(DEPTH));
   assign out_valid = (fill != '0);
   assign push      = in_valid && !full;
   assign pop       = out_ready && !empty;

   alu_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PAY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (push_data),
      .rdata (head_data),
      .count (fill),
      .full  (full),
      .empty (empty)
   );

   assign out_result = head_data[DATA_W-1:0];
   assign out_flags  = head_data[DATA_W +: FLAG_W];
   assign out_opcode = head_data[DATA_W + FLAG_W +: 4];
`ifdef ALU_RESULT_PARITY_EN
   assign out_parity = head_data[PAY_W-1];
`endif

   always_ff @(posedge clk) begin
      if (rst)      op_count <= '0;
      else if (pop) op_count <= op_count + CNT_W'(1);
   end

endmodule
